// File: rtl/rtc_bus_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_writer_pkg
// Brief    : Shared RTC bus state encoding, default strobe timing and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rtc_bus_writer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_SETUP  = 4'd1,
        ST_A_STROBE = 4'd2,
        ST_A_HOLD   = 4'd3,
        ST_GAP      = 4'd4,
        ST_D_SETUP  = 4'd5,
        ST_D_STROBE = 4'd6,
        ST_D_HOLD   = 4'd7,
        ST_FINISH   = 4'd8
    } rtc_state_t;

    typedef struct packed {
        logic cs_n;
        logic wr_n;
        logic oe;
        logic sel;
    } rtc_bus_ctl_t;

    localparam int c_DEF_SETUP_CYC = 4;
    localparam int c_DEF_PULSE_CYC = 10;
    localparam int c_DEF_HOLD_CYC  = 4;
    localparam int c_DEF_GAP_CYC   = 4;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Wide enough to hold the largest cycle count itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic is_addr_phase(input rtc_state_t st);
        return (st == ST_A_SETUP) || (st == ST_A_STROBE) || (st == ST_A_HOLD);
    endfunction

    function automatic logic is_data_phase(input rtc_state_t st);
        return (st == ST_D_SETUP) || (st == ST_D_STROBE) || (st == ST_D_HOLD);
    endfunction

    function automatic rtc_bus_ctl_t bus_ctl(input rtc_state_t st);
        rtc_bus_ctl_t c;
        c.cs_n = !(is_addr_phase(st) || is_data_phase(st));
        c.oe   = !c.cs_n;
        c.sel  = is_data_phase(st);
        c.wr_n = !((st == ST_A_STROBE) || (st == ST_D_STROBE));
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_writer_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_cycle_timer
// Brief    : Loadable down-counter that stops at zero and flags it.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_writer
// Brief    : Writes one RTC register over the multiplexed AD bus: address
//            phase, bus-release gap, data phase, then a one-cycle done.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_writer
    import rtc_bus_writer_pkg::*;
#(
    parameter int SETUP_CYC = c_DEF_SETUP_CYC,
    parameter int PULSE_CYC = c_DEF_PULSE_CYC,
    parameter int HOLD_CYC  = c_DEF_HOLD_CYC,
    parameter int GAP_CYC   = c_DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n
);

    localparam int c_MAX_CYC = max_of4(SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC);
    localparam int c_CNT_W   = cnt_width(c_MAX_CYC);

    // The timer is loaded with N-1 so that a state lasts exactly N cycles.
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD   = c_CNT_W'(GAP_CYC - 1);

    rtc_state_t         r_state;
    rtc_state_t         w_state_nxt;
    rtc_bus_ctl_t       w_ctl_nxt;
    logic               w_accept;
    logic               w_load;
    logic               w_zero;
    logic [c_CNT_W-1:0] w_load_val;
    logic [7:0]         w_ad_nxt;
    logic [7:0]         r_addr;
    logic [7:0]         r_wdata;

    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_ad_out;
    logic               r_ad_oe;
    logic               r_ad_sel;
    logic               r_cs_n;
    logic               r_rd_n;
    logic               r_wr_n;

    rtc_cycle_timer #(
        .WIDTH    (c_CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    assign w_accept = (r_state == ST_IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_A_SETUP;
                    w_load      = 1'b1;
                    w_load_val  = c_SETUP_LD;
                end
            end
            ST_A_SETUP: begin
                if (w_zero) begin
                    w_state_nxt = ST_A_STROBE;
                    w_load      = 1'b1;
                    w_load_val  = c_PULSE_LD;
                end
            end
            ST_A_STROBE: begin
                if (w_zero) begin
                    w_state_nxt = ST_A_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = c_HOLD_LD;
                end
            end
            ST_A_HOLD: begin
                if (w_zero) begin
                    w_state_nxt = ST_GAP;
                    w_load      = 1'b1;
                    w_load_val  = c_GAP_LD;
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_state_nxt = ST_D_SETUP;
                    w_load      = 1'b1;
                    w_load_val  = c_SETUP_LD;
                end
            end
            ST_D_SETUP: begin
                if (w_zero) begin
                    w_state_nxt = ST_D_STROBE;
                    w_load      = 1'b1;
                    w_load_val  = c_PULSE_LD;
                end
            end
            ST_D_STROBE: begin
                if (w_zero) begin
                    w_state_nxt = ST_D_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = c_HOLD_LD;
                end
            end
            ST_D_HOLD: begin
                if (w_zero) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it;
    // on the accepting edge the address comes straight from the port.
    assign w_ctl_nxt = bus_ctl(w_state_nxt);

    always_comb begin
        w_ad_nxt = 8'h00;
        if (is_addr_phase(w_state_nxt)) begin
            w_ad_nxt = w_accept ? addr : r_addr;
        end else if (is_data_phase(w_state_nxt)) begin
            w_ad_nxt = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ad_out <= 8'h00;
            r_ad_oe  <= 1'b0;
            r_ad_sel <= 1'b0;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= (w_state_nxt == ST_FINISH);
            r_ad_out <= w_ad_nxt;
            r_ad_oe  <= w_ctl_nxt.oe;
            r_ad_sel <= w_ctl_nxt.sel;
            r_cs_n   <= w_ctl_nxt.cs_n;
            r_rd_n   <= 1'b1;
            r_wr_n   <= w_ctl_nxt.wr_n;
        end
    end

    always_ff @(posedge clk) begin : p_param_chk
        if (reset) begin
            assert (SETUP_CYC >= 1 && PULSE_CYC >= 1 && HOLD_CYC >= 1 && GAP_CYC >= 1)
                else $error("rtc_bus_writer: all timing parameters must be >= 1");
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ad_out = r_ad_out;
    assign ad_oe  = r_ad_oe;
    assign ad_sel = r_ad_sel;
    assign cs_n   = r_cs_n;
    assign rd_n   = r_rd_n;
    assign wr_n   = r_wr_n;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rtc_bus_writer
// Brief    : Self-checking bench for rtc_bus_writer (default and all-1 timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_writer;

    localparam int c_S [2] = '{4, 1};
    localparam int c_P [2] = '{10, 1};
    localparam int c_H [2] = '{4, 1};
    localparam int c_G [2] = '{4, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;

    logic [1:0] busy, done, ad_oe, ad_sel, cs_n, rd_n, wr_n;
    logic [7:0] ad_out [2];

    int n_checks = 0;
    int n_errors = 0;
    int n_done [2] = '{0, 0};
    int m_k [2] = '{0, 0};
    logic [7:0] m_a [2];
    logic [7:0] m_d [2];
    logic mon_en = 1'b0;

    int n, n_one, cnt_a, cnt_d, gap, d0, d1;

    always #5 clk = ~clk;

    rtc_bus_writer dut_def (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
        .busy(busy[0]), .done(done[0]), .ad_out(ad_out[0]), .ad_oe(ad_oe[0]),
        .ad_sel(ad_sel[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0])
    );

    rtc_bus_writer #(
        .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .GAP_CYC(1)
    ) dut_one (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
        .busy(busy[1]), .done(done[1]), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]),
        .ad_sel(ad_sel[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int txn_len(input int i);
        return 2 * (c_S[i] + c_P[i] + c_H[i]) + c_G[i] + 1;
    endfunction

    // Expected bus for cycle k of a transaction (k=0: idle), packed as
    // {busy, done, cs_n, rd_n, wr_n, ad_oe, ad_sel, ad_out}.
    function automatic logic [14:0] exp_bus(input int i, input int k,
                                            input logic [7:0] a, input logic [7:0] d);
        int t, j;
        logic cs, wr, sel;
        logic [7:0] o;
        t = c_S[i] + c_P[i] + c_H[i];
        cs = 1'b1; wr = 1'b1; sel = 1'b0; o = 8'h00; j = 0;
        if (k >= 1 && k <= t) begin
            cs = 1'b0; o = a; j = k;
        end else if (k > t + c_G[i] && k <= 2 * t + c_G[i]) begin
            cs = 1'b0; sel = 1'b1; o = d; j = k - t - c_G[i];
        end
        if (j > c_S[i] && j <= c_S[i] + c_P[i]) wr = 1'b0;
        return {(k != 0), (k == txn_len(i)), cs, 1'b1, wr, ~cs, sel, o};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_k[i] = 0;
            end else if (m_k[i] == 0) begin
                if (start) begin
                    m_k[i] = 1; m_a[i] = addr; m_d[i] = wdata;
                end
            end else if (m_k[i] == txn_len(i)) begin
                m_k[i] = 0;
            end else begin
                m_k[i] = m_k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) n_done[i]++;
        end
    end

    // ad_sel is only defined while the bus is driven, so mask it otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [14:0] e, o, msk;
                e = exp_bus(i, m_k[i], m_a[i], m_d[i]);
                o = {busy[i], done[i], cs_n[i], rd_n[i], wr_n[i], ad_oe[i], ad_sel[i], ad_out[i]};
                msk = e[12] ? 15'h7EFF : 15'h7FFF;
                check_val(i == 0 ? "bus_def" : "bus_one", 32'(o & msk), 32'(e & msk));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, input int budget, input string tag);
        int c = 0;
        while (c < budget && done[i] !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        if (done[i] !== 1'b1) check_val(tag, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy",  busy[0],   0);
        check_val("rst_done",  done[0],   0);
        check_val("rst_cs_n",  cs_n[0],   1);
        check_val("rst_rd_n",  rd_n[0],   1);
        check_val("rst_wr_n",  wr_n[0],   1);
        check_val("rst_ad_oe", ad_oe[0],  0);
        check_val("rst_sel",   ad_sel[0], 0);
        check_val("rst_adout", ad_out[0], 0);
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Default write 0x23/0x15, all-1 instance runs alongside.
        start = 1'b1; addr = 8'h23; wdata = 8'h15;
        @(posedge clk); #1; start = 1'b0;
        n = 0; n_one = -1; cnt_a = 0; cnt_d = 0;
        while (n < 100 && done[0] !== 1'b1) begin
            @(negedge clk); n++;
            if (done[1] === 1'b1 && n_one < 0) n_one = n;
            if (wr_n[0] === 1'b0 && ad_sel[0] === 1'b0 && ad_out[0] === 8'h23) cnt_a++;
            if (wr_n[0] === 1'b0 && ad_sel[0] === 1'b1 && ad_out[0] === 8'h15) cnt_d++;
        end
        check_val("len_def", n, 41);
        check_val("len_one", n_one, 8);
        check_val("wr_low_addr", cnt_a, 10);
        check_val("wr_low_data", cnt_d, 10);
        repeat (10) tick();

        // Second start mid-transaction is ignored.
        d0 = n_done[0];
        start = 1'b1; addr = 8'h31; wdata = 8'h42;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) tick();
        start = 1'b1; addr = 8'h55; wdata = 8'h66;
        tick(); start = 1'b0;
        wait_done(0, 60, "tmo_ignore");
        repeat (5) tick();
        check_val("ignored_start_done", n_done[0] - d0, 1);
        repeat (10) tick();

        // Reset during D_STROBE aborts without done.
        d0 = n_done[0];
        start = 1'b1; addr = 8'h44; wdata = 8'h99;
        @(posedge clk); #1; start = 1'b0;
        repeat (29) tick();
        check_val("in_d_strobe", {ad_sel[0], wr_n[0]}, 2'b10);
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check_val("abort_wr_n",  wr_n[0],  1);
        check_val("abort_cs_n",  cs_n[0],  1);
        check_val("abort_ad_oe", ad_oe[0], 0);
        check_val("abort_busy",  busy[0],  0);
        repeat (50) tick();
        check_val("abort_no_done", n_done[0] - d0, 0);

        // Back-to-back: second start in the first IDLE cycle after FINISH.
        d0 = n_done[0];
        start = 1'b1; addr = 8'h21; wdata = 8'h08;
        @(posedge clk); #1; start = 1'b0;
        wait_done(0, 60, "tmo_b2b_1");
        gap = (cs_n[0] === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b1; addr = 8'h22; wdata = 8'h30;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (n < 20 && cs_n[0] !== 1'b0) begin
            @(negedge clk); n++;
            if (cs_n[0] === 1'b1) gap++;
        end
        check_val("cs_gap_ge1", (gap >= 1), 1);
        wait_done(0, 60, "tmo_b2b_2");
        repeat (5) tick();
        check_val("b2b_two_done", n_done[0] - d0, 2);
        repeat (10) tick();

        // Start during FINISH is dropped.
        d0 = n_done[0];
        start = 1'b1; addr = 8'h10; wdata = 8'h20;
        @(posedge clk); #1; start = 1'b0;
        wait_done(0, 60, "tmo_finish");
        start = 1'b1; addr = 8'h77; wdata = 8'h88;
        @(posedge clk); #1; start = 1'b0;
        repeat (60) tick();
        check_val("finish_start_dropped", n_done[0] - d0, 1);
        check_val("finish_idle_busy", busy[0], 0);

        // Inputs churn every cycle during a transaction.
        d0 = n_done[0]; d1 = n_done[1];
        start = 1'b1; addr = 8'h5A; wdata = 8'hA5;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 45; c++) begin
            addr = 8'($urandom); wdata = 8'($urandom);
            tick();
        end
        check_val("churn_done", n_done[0] - d0, 1);
        check_val("churn_one_done", n_done[1] - d1, 1);
        repeat (5) tick();

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 9) == 0);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        start = 1'b0; reset = 1'b0;
        repeat (60) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
